// File: rtl/ipsmacge_rxlenchk.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ipsmacge_rxlenchk : receive-side frame length checker (giant truncate, runt flag, stats)
// Revision 1.0
// ----------------------------------------------------------------------------
module ipsmacge_rxlenchk #(
   parameter int MAC_DW = 32,
   parameter int MAC_BW = 2,
   parameter int MAC_EW = 4,
   parameter int LEN_W  = 14,
   parameter int CNT_W  = 16
) (
   input  logic              maclk,
   input  logic              marst_,
   input  logic [MAC_DW-1:0] ma_idat,
   input  logic [MAC_BW-1:0] ma_inob,
   input  logic              ma_ivld,
   input  logic              ma_isop,
   input  logic              ma_ieop,
   input  logic [MAC_EW-1:0] ma_ierr,
   input  logic              upact,
   input  logic [LEN_W-1:0]  cfg_minlen,
   input  logic [LEN_W-1:0]  cfg_maxlen,
   input  logic              cnt_clr,
   output logic [MAC_DW-1:0] pk_odat,
   output logic [MAC_BW-1:0] pk_onob,
   output logic              pk_ovld,
   output logic              pk_osop,
   output logic              pk_oeop,
   output logic [MAC_EW+1:0] pk_oerr,
   output logic [CNT_W-1:0]  cnt_frm,
   output logic [CNT_W-1:0]  cnt_runt,
   output logic [CNT_W-1:0]  cnt_giant,
   output logic [CNT_W-1:0]  cnt_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FRAME = 2'd1;
   localparam logic [1:0] ST_TRUNC = 2'd2;
   localparam int         NW       = LEN_W + 1;

   logic [1:0]        state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;

   logic              w_acc;
   logic              w_fwd;
   logic              w_abort;
   logic              w_giant;
   logic              w_runt;
   logic              w_oeop;
   logic [NW-1:0]     w_nlen;
   logic [MAC_EW-1:0] w_ierr;
   logic [1:0]        w_err_inc;

   logic [MAC_DW-1:0] pk_odat_q, pk_odat_d;
   logic [MAC_BW-1:0] pk_onob_q, pk_onob_d;
   logic              pk_ovld_q, pk_ovld_d;
   logic              pk_osop_q, pk_osop_d;
   logic              pk_oeop_q, pk_oeop_d;
   logic [MAC_EW+1:0] pk_oerr_q, pk_oerr_d;

   logic [CNT_W-1:0]  cnt_frm_q,   cnt_frm_d;
   logic [CNT_W-1:0]  cnt_runt_q,  cnt_runt_d;
   logic [CNT_W-1:0]  cnt_giant_q, cnt_giant_d;
   logic [CNT_W-1:0]  cnt_err_q,   cnt_err_d;

   // Saturating add of a 0..2 increment; an abort and an errored eop can coincide.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                input logic [1:0]       inc);
      logic [CNT_W:0] s;
      s = {1'b0, c} + (CNT_W+1)'(inc);
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   always_comb begin
      w_acc     = ma_ivld & upact;
      w_nlen    = (ma_isop ? NW'(0) : NW'(len_q)) + NW'(ma_inob) + NW'(1);
      w_giant   = (w_nlen > NW'(cfg_maxlen));
      w_fwd     = w_acc & (ma_isop | (state_q == ST_FRAME));
      w_abort   = w_acc & ma_isop & (state_q != ST_IDLE);
      w_oeop    = ma_ieop | w_giant;
      w_runt    = ma_ieop & ~w_giant & (w_nlen < NW'(cfg_minlen));
      w_ierr    = ma_ieop ? ma_ierr : {MAC_EW{1'b0}};
      w_err_inc = {1'b0, w_abort} + {1'b0, w_fwd & ma_ieop & (|ma_ierr)};

      state_d = state_q;
      len_d   = len_q;
      if (w_fwd) begin
         len_d = w_nlen[LEN_W] ? {LEN_W{1'b1}} : w_nlen[LEN_W-1:0];
         if (w_giant && !ma_ieop) begin
            state_d = ST_TRUNC;
         end else if (ma_ieop) begin
            state_d = ST_IDLE;
         end else begin
            state_d = ST_FRAME;
         end
      end else if (w_acc && ma_ieop && (state_q == ST_TRUNC)) begin
         state_d = ST_IDLE;
      end
   end

   always_comb begin
      pk_ovld_d = w_fwd;
      pk_odat_d = w_fwd ? ma_idat : {MAC_DW{1'b0}};
      pk_onob_d = w_fwd ? ma_inob : {MAC_BW{1'b0}};
      pk_osop_d = w_fwd & ma_isop;
      pk_oeop_d = w_fwd & w_oeop;
      pk_oerr_d = w_fwd ? {w_giant, w_runt, w_ierr} : {(MAC_EW+2){1'b0}};
   end

   always_comb begin
      if (cnt_clr) begin
         cnt_frm_d   = {CNT_W{1'b0}};
         cnt_runt_d  = {CNT_W{1'b0}};
         cnt_giant_d = {CNT_W{1'b0}};
         cnt_err_d   = {CNT_W{1'b0}};
      end else begin
         cnt_frm_d   = sat_add(cnt_frm_q,   {1'b0, w_fwd & w_oeop});
         cnt_runt_d  = sat_add(cnt_runt_q,  {1'b0, w_fwd & w_runt});
         cnt_giant_d = sat_add(cnt_giant_q, {1'b0, w_fwd & w_giant});
         cnt_err_d   = sat_add(cnt_err_q,   w_err_inc);
      end
   end

   always_ff @(posedge maclk or negedge marst_) begin
      if (!marst_) begin
         state_q     <= ST_IDLE;
         len_q       <= {LEN_W{1'b0}};
         pk_odat_q   <= {MAC_DW{1'b0}};
         pk_onob_q   <= {MAC_BW{1'b0}};
         pk_ovld_q   <= 1'b0;
         pk_osop_q   <= 1'b0;
         pk_oeop_q   <= 1'b0;
         pk_oerr_q   <= {(MAC_EW+2){1'b0}};
         cnt_frm_q   <= {CNT_W{1'b0}};
         cnt_runt_q  <= {CNT_W{1'b0}};
         cnt_giant_q <= {CNT_W{1'b0}};
         cnt_err_q   <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         pk_odat_q   <= pk_odat_d;
         pk_onob_q   <= pk_onob_d;
         pk_ovld_q   <= pk_ovld_d;
         pk_osop_q   <= pk_osop_d;
         pk_oeop_q   <= pk_oeop_d;
         pk_oerr_q   <= pk_oerr_d;
         cnt_frm_q   <= cnt_frm_d;
         cnt_runt_q  <= cnt_runt_d;
         cnt_giant_q <= cnt_giant_d;
         cnt_err_q   <= cnt_err_d;
      end
   end

   assign pk_odat   = pk_odat_q;
   assign pk_onob   = pk_onob_q;
   assign pk_ovld   = pk_ovld_q;
   assign pk_osop   = pk_osop_q;
   assign pk_oeop   = pk_oeop_q;
   assign pk_oerr   = pk_oerr_q;
   assign cnt_frm   = cnt_frm_q;
   assign cnt_runt  = cnt_runt_q;
   assign cnt_giant = cnt_giant_q;
   assign cnt_err   = cnt_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ipsmacge_rxlenchk.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ipsmacge_rxlenchk : directed frames against a frame-level model, two counter widths
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_ipsmacge_rxlenchk;

   localparam int MINL = 64;
   localparam int MAXL = 1518;

   logic        maclk = 1'b0;
   logic        marst_ = 1'b0;
   logic [31:0] ma_idat = '0;
   logic [1:0]  ma_inob = '0;
   logic        ma_ivld = 1'b0;
   logic        ma_isop = 1'b0;
   logic        ma_ieop = 1'b0;
   logic [3:0]  ma_ierr = '0;
   logic        upact = 1'b1;
   logic [13:0] cfg_minlen = 14'(MINL);
   logic [13:0] cfg_maxlen = 14'(MAXL);
   logic        cnt_clr = 1'b0;

   logic [31:0] a_dat;
   logic [1:0]  a_nob;
   logic        a_vld, a_sop, a_eop;
   logic [5:0]  a_err;
   logic [15:0] a_frm, a_runt, a_giant, a_cerr;

   logic [31:0] b_dat;
   logic [1:0]  b_nob;
   logic        b_vld, b_sop, b_eop;
   logic [5:0]  b_err;
   logic [3:0]  b_frm, b_runt, b_giant, b_cerr;

   ipsmacge_rxlenchk dut16 (
      .maclk(maclk), .marst_(marst_), .ma_idat(ma_idat), .ma_inob(ma_inob),
      .ma_ivld(ma_ivld), .ma_isop(ma_isop), .ma_ieop(ma_ieop), .ma_ierr(ma_ierr),
      .upact(upact), .cfg_minlen(cfg_minlen), .cfg_maxlen(cfg_maxlen), .cnt_clr(cnt_clr),
      .pk_odat(a_dat), .pk_onob(a_nob), .pk_ovld(a_vld), .pk_osop(a_sop),
      .pk_oeop(a_eop), .pk_oerr(a_err), .cnt_frm(a_frm), .cnt_runt(a_runt),
      .cnt_giant(a_giant), .cnt_err(a_cerr)
   );

   ipsmacge_rxlenchk #(.CNT_W(4)) dut4 (
      .maclk(maclk), .marst_(marst_), .ma_idat(ma_idat), .ma_inob(ma_inob),
      .ma_ivld(ma_ivld), .ma_isop(ma_isop), .ma_ieop(ma_ieop), .ma_ierr(ma_ierr),
      .upact(upact), .cfg_minlen(cfg_minlen), .cfg_maxlen(cfg_maxlen), .cnt_clr(cnt_clr),
      .pk_odat(b_dat), .pk_onob(b_nob), .pk_ovld(b_vld), .pk_osop(b_sop),
      .pk_oeop(b_eop), .pk_oerr(b_err), .cnt_frm(b_frm), .cnt_runt(b_runt),
      .cnt_giant(b_giant), .cnt_err(b_cerr)
   );

   always #5 maclk = ~maclk;

   int n_chk = 0;
   int n_fail = 0;
   int ow = 0;
   logic [5:0] last_err = '0;

   // Model: 0 = waiting for sop, 1 = inside a frame, 2 = dropping rest of a giant.
   int m_mode = 0;
   int m_bytes = 0;
   int m16_frm = 0, m16_runt = 0, m16_giant = 0, m16_err = 0;
   int m4_frm = 0, m4_runt = 0, m4_giant = 0, m4_err = 0;
   logic        e_vld = 1'b0, e_sop = 1'b0, e_eop = 1'b0;
   logic [31:0] e_dat = '0;
   logic [1:0]  e_nob = '0;
   logic [5:0]  e_err = '0;

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_bytes = 0;
      m16_frm = 0; m16_runt = 0; m16_giant = 0; m16_err = 0;
      m4_frm = 0; m4_runt = 0; m4_giant = 0; m4_err = 0;
      e_vld = 0; e_sop = 0; e_eop = 0; e_dat = '0; e_nob = '0; e_err = '0;
   endtask

   task automatic model_step();
      int nb, i_frm, i_runt, i_giant, i_err;
      bit g, r;
      i_frm = 0; i_runt = 0; i_giant = 0; i_err = 0;
      e_vld = 0; e_sop = 0; e_eop = 0; e_dat = '0; e_nob = '0; e_err = '0;
      if (ma_ivld && upact) begin
         nb = (ma_isop ? 0 : m_bytes) + int'(ma_inob) + 1;
         if (ma_isop && m_mode != 0) i_err++;
         if (ma_isop || m_mode == 1) begin
            g = (nb > MAXL);
            r = ma_ieop && !g && (nb < MINL);
            e_vld = 1; e_dat = ma_idat; e_nob = ma_inob; e_sop = ma_isop;
            e_eop = ma_ieop || g;
            e_err = {g, r, (ma_ieop ? ma_ierr : 4'h0)};
            if (e_eop) i_frm++;
            if (g) i_giant++;
            if (r) i_runt++;
            if (ma_ieop && ma_ierr != 0) i_err++;
            m_bytes = sat(nb, 16383);
            m_mode = (g && !ma_ieop) ? 2 : (ma_ieop ? 0 : 1);
         end else if (m_mode == 2 && ma_ieop) begin
            m_mode = 0;
         end
      end
      if (cnt_clr) begin
         m16_frm = 0; m16_runt = 0; m16_giant = 0; m16_err = 0;
         m4_frm = 0; m4_runt = 0; m4_giant = 0; m4_err = 0;
      end else begin
         m16_frm = sat(m16_frm + i_frm, 65535);   m4_frm = sat(m4_frm + i_frm, 15);
         m16_runt = sat(m16_runt + i_runt, 65535); m4_runt = sat(m4_runt + i_runt, 15);
         m16_giant = sat(m16_giant + i_giant, 65535); m4_giant = sat(m4_giant + i_giant, 15);
         m16_err = sat(m16_err + i_err, 65535);   m4_err = sat(m4_err + i_err, 15);
      end
   endtask

   // One call per cycle: inputs change on the falling edge, the model predicts the next rising edge.
   task automatic drive(input bit sop, input bit eop, input logic [1:0] nob,
                        input logic [3:0] ierr, input bit vld, input bit up, input bit clr);
      @(negedge maclk);
      ma_isop = sop; ma_ieop = eop; ma_inob = nob; ma_ierr = ierr;
      ma_ivld = vld; upact = up; cnt_clr = clr; ma_idat = $urandom;
      model_step();
   endtask

   task automatic idle(input bit clr);
      drive(0, 0, 2'd0, 4'h0, 0, 1, clr);
   endtask

   task automatic send_words(input int nbytes, input int wf, input int wt,
                             input logic [3:0] ierr, input bit clr_last, input bit up);
      int nw;
      bit eop;
      nw = (nbytes + 3) / 4;
      for (int w = wf; w <= wt; w++) begin
         eop = (w == nw);
         drive(w == 1, eop, eop ? 2'((nbytes - 1) % 4) : 2'd3, eop ? ierr : 4'h0,
               1, up, clr_last && eop);
      end
   endtask

   task automatic frame(input int nbytes, input logic [3:0] ierr);
      send_words(nbytes, 1, (nbytes + 3) / 4, ierr, 0, 1);
      idle(0);
   endtask

   task automatic do_reset();
      @(negedge maclk);
      marst_ = 1'b0;
      ma_ivld = 1'b0; cnt_clr = 1'b0;
      model_reset();
      idle(0);
      idle(0);
      marst_ = 1'b1;
   endtask

   always @(posedge maclk) begin
      #1;
      chk("ovld", 32'(a_vld), 32'(e_vld));
      if (e_vld) begin
         chk("odat", a_dat, e_dat);
         chk("onob", 32'(a_nob), 32'(e_nob));
         chk("osop", 32'(a_sop), 32'(e_sop));
         chk("oeop", 32'(a_eop), 32'(e_eop));
         chk("oerr", 32'(a_err), 32'(e_err));
      end
      chk("cnt_frm", 32'(a_frm), 32'(m16_frm));
      chk("cnt_runt", 32'(a_runt), 32'(m16_runt));
      chk("cnt_giant", 32'(a_giant), 32'(m16_giant));
      chk("cnt_err", 32'(a_cerr), 32'(m16_err));
      chk("w4_ovld", 32'(b_vld), 32'(e_vld));
      chk("w4_cnt_frm", 32'(b_frm), 32'(m4_frm));
      chk("w4_cnt_err", 32'(b_cerr), 32'(m4_err));
      if (a_vld) ow++;
      if (a_vld && a_eop) last_err = a_err;
   end

   initial begin
      repeat (3) idle(0);
      chk("reset_ovld", 32'(a_vld), 32'd0);
      chk("reset_cnt_frm", 32'(a_frm), 32'd0);
      marst_ = 1'b1;
      idle(0);

      // 64-byte legal frame
      idle(1); ow = 0;
      frame(64, 4'h0);
      chk("f64_words", 32'(ow), 32'd16);
      chk("f64_oerr", 32'(last_err), 32'h00);
      chk("f64_cnt_frm", 32'(a_frm), 32'd1);

      // 61-byte runt
      idle(1); ow = 0;
      frame(61, 4'h0);
      chk("f61_words", 32'(ow), 32'd16);
      chk("f61_oerr", 32'(last_err), 32'h10);
      chk("f61_cnt_runt", 32'(a_runt), 32'd1);
      chk("f61_cnt_frm", 32'(a_frm), 32'd1);

      // 1600-byte giant, truncated after 1520 bytes
      idle(1); ow = 0;
      frame(1600, 4'h0);
      chk("f1600_words", 32'(ow), 32'd380);
      chk("f1600_oerr", 32'(last_err), 32'h20);
      chk("f1600_cnt_giant", 32'(a_giant), 32'd1);

      // length boundaries and error passthrough
      idle(1);
      frame(1518, 4'h0);
      chk("f1518_oerr", 32'(last_err), 32'h00);
      frame(1519, 4'h0);
      chk("f1519_oerr", 32'(last_err), 32'h20);
      frame(63, 4'h0);
      chk("f63_oerr", 32'(last_err), 32'h10);
      frame(100, 4'h5);
      chk("ierr_oerr", 32'(last_err), 32'h05);
      chk("ierr_cnt_err", 32'(a_cerr), 32'd1);
      frame(10, 4'h2);
      chk("runt_ierr_oerr", 32'(last_err), 32'h12);

      // sop arrives in word 5 of an open frame
      idle(1); ow = 0;
      send_words(64, 1, 4, 4'h0, 0, 1);
      frame(64, 4'h0);
      chk("abort_words", 32'(ow), 32'd20);
      chk("abort_cnt_err", 32'(a_cerr), 32'd1);
      chk("abort_cnt_frm", 32'(a_frm), 32'd1);

      // counter saturation on the narrow instance and clear priority
      idle(1);
      for (int k = 0; k < 17; k++) frame(64, 4'h0);
      chk("sat_cnt_frm4", 32'(b_frm), 32'd15);
      chk("sat_cnt_frm16", 32'(a_frm), 32'd17);
      send_words(64, 1, 16, 4'h0, 1, 1);
      idle(0);
      chk("clr_cnt_frm4", 32'(b_frm), 32'd0);
      chk("clr_cnt_frm16", 32'(a_frm), 32'd0);

      // reset in the middle of a frame, tail words arrive without sop
      frame(64, 4'h0);
      send_words(64, 1, 8, 4'h0, 0, 1);
      do_reset();
      ow = 0;
      send_words(64, 9, 16, 4'h0, 0, 1);
      idle(0);
      chk("rst_tail_words", 32'(ow), 32'd0);
      chk("rst_cnt_frm", 32'(a_frm), 32'd0);

      // port disabled for a whole frame
      ow = 0;
      send_words(64, 1, 16, 4'h3, 0, 0);
      idle(0);
      chk("upact0_words", 32'(ow), 32'd0);
      chk("upact0_cnt_err", 32'(a_cerr), 32'd0);

      idle(0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
